multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main control unit for the multicycle MIPS datapath: a Moore state machine, with memory-ready qualification, that sequences instruction fetch, decode, execute, memory access and write-back. It drives every datapath mux select and write enable: RegDst, IorD, MemtoReg, ALUSrcA, ALUSrcB and PCSource, plus the PC, IR, memory and register-file enables. It sits beside the datapath top and receives only the opcode field of the instruction register and a memory-ready strobe.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- Op  in  6  instruction opcode, IR[31:26]
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU Zero
- IorD  out  1  0=PC, 1=ALUOut as memory address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  0=ALUOut, 1=MDR to register write data
- RegDst  out  1  0=IR[20:16], 1=IR[15:11]
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=register A
- ALUSrcB  out  2  0=B, 1=constant 4, 2=sign-extend, 3=sign-extend<<2
- ALUOp  out  2  0=add, 1=sub, 2=funct-decoded
- PCSource  out  2  0=ALUResult, 1=ALUOut, 2=jump target
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state_dbg  out  4  current state encoding

## Operation
- States and their Moore outputs (unlisted outputs are 0):
  - FETCH(0): MemRead, ALUSrcB=1, ALUOp=0. IRWrite and PCWrite are asserted only when mem_ready=1.
  - DECODE(1): ALUSrcB=3, ALUOp=0.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=2.
  - MEMRD(3): MemRead, IorD.
  - MEMWB(4): RegWrite, MemtoReg.
  - MEMWR(5): IorD. MemWrite is asserted while in the state.
  - EXEC(6): ALUSrcA=1, ALUOp=2.
  - ALUWB(7): RegWrite, RegDst.
  - BRANCH(8): ALUSrcA=1, ALUOp=1, PCWriteCond, PCSource=1.
  - JUMP(9): PCWrite, PCSource=2.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=2.
  - ADDIWB(11): RegWrite.
- Transitions:
  - FETCH→DECODE when mem_ready; otherwise hold in FETCH.
  - DECODE dispatches on Op:
    - 000000→EXEC
    - 100011 or 101011→MEMADR
    - 000100→BRANCH
    - 000010→JUMP
    - 001000→ADDIEX
    - any other opcode→FETCH, with illegal_op pulsed.
  - MEMADR→MEMRD for lw, →MEMWR for sw. Op is sampled again here; IR is stable.
  - MEMRD→MEMWB when mem_ready; otherwise hold.
  - MEMWR→FETCH when mem_ready; otherwise hold.
  - EXEC→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all go →FETCH.
- Unused encodings 12–15 go to FETCH on the next edge, with all enables 0 while in them.

## Timing
- rst=1 at an edge puts the state in FETCH; this may interrupt any state, including a held memory access.
- While rst=1, PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite and RegWrite are forced to 0, and illegal_op=0. All selects are 0 and state_dbg=0.
- Select outputs are a function of the state register only. The enables qualified by mem_ready (IRWrite and PCWrite in FETCH) are combinational on mem_ready.
- Cycle counts with mem_ready tied to 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Requests stay asserted with a stable address until mem_ready.
- illegal_op is high for exactly the DECODE cycle; the next state is FETCH.

## Configuration
- CTRL_ADDI_EN:
  - Defined: ADDIEX and ADDIWB exist, and opcode 001000 executes as addi.
  - Undefined: both states are removed, their encodings behave as unused, and 001000 is illegal (illegal_op pulse, return to FETCH).

## Structure
- Shared package ctrl_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp, ALUSrcB and PCSource select constants.
- One sub-module, ctrl_output_decode: a purely combinational state→control-word decoder, with rst and mem_ready gating applied in the top.

## Test plan
- Reset: assert rst for 2 cycles mid-MEMRD → state_dbg=0, all enables 0 during reset; with Op=100011 and mem_ready=1 afterwards, MemRead=1 and IRWrite=1 in the first cycle.
- lw with mem_ready=1: Op=100011 → states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWR → MemWrite and IorD held for 4 cycles, then FETCH; RegWrite never 1.
- beq Op=000100 → BRANCH with PCWriteCond=1, ALUOp=1, PCSource=1 for one cycle; j Op=000010 → PCWrite=1, PCSource=2.
- Op=111111 → illegal_op=1 for one cycle in DECODE, next state FETCH.
- Op=001000:
  - with CTRL_ADDI_EN: states 0,1,10,11,0, with RegWrite=1 and RegDst=0 in ADDIWB.
  - without CTRL_ADDI_EN: illegal_op pulse.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode constants, datapath select constants and the control-word layout.
// Optional feature macro: CTRL_ADDI_EN (addi support).
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REG   = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // readyQual marks a state whose pcWrite/irWrite only take effect when
  // memory completes the access in the same cycle.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       readyQual;
  } ctrlWord_t;

  localparam ctrlWord_t CTRL_IDLE = '0;

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational state -> control-word decoder. Reset and mem_ready gating
// are applied by the caller. Optional feature macro: CTRL_ADDI_EN.
module ctrl_output_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrlWord_t  ctrl
);

  // Moore control word per state; unused encodings leave everything idle.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.memRead   = 1'b1;
        ctrl.aluSrcB   = SRCB_FOUR;
        ctrl.aluOp     = ALUOP_ADD;
        ctrl.irWrite   = 1'b1;
        ctrl.pcWrite   = 1'b1;
        ctrl.readyQual = 1'b1;
      end
      S_DECODE: begin
        ctrl.aluSrcB = SRCB_IMMSH;
        ctrl.aluOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.memRead = 1'b1;
        ctrl.iorD    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.memtoReg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iorD     = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      S_EXEC: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regWrite = 1'b1;
        ctrl.regDst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.aluSrcA     = 1'b1;
        ctrl.aluOp       = ALUOP_SUB;
        ctrl.pcWriteCond = 1'b1;
        ctrl.pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcWrite  = 1'b1;
        ctrl.pcSource = PCSRC_JUMP;
      end
`ifdef CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regWrite = 1'b1;
      end
`endif
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS datapath. Moore outputs come from
// ctrl_output_decode; this level adds reset forcing and mem_ready
// qualification of the fetch-cycle IR/PC loads.
// Optional feature macro: CTRL_ADDI_EN (adds ADDIEX/ADDIWB and opcode 001000).
//
// state  | meaning
// -------+-----------------------------------------------
// FETCH  | read instruction; IR/PC load when mem_ready
// DECODE | register read, branch target calc, dispatch
// MEMADR | lw/sw effective address
// MEMRD  | lw data read, held until mem_ready
// MEMWB  | lw register write-back from MDR
// MEMWR  | sw data write, held until mem_ready
// EXEC   | R-type ALU operation
// ALUWB  | R-type write-back to rd
// BRANCH | beq compare, conditional PC load
// JUMP   | j target PC load
// ADDIEX | addi ALU operation (CTRL_ADDI_EN only)
// ADDIWB | addi write-back to rt (CTRL_ADDI_EN only)
module multicycle_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t    state;
  state_t    stateNext;
  logic      illegalRaw;
  ctrlWord_t ctrlRaw;
  ctrlWord_t ctrlGated;

  // State register; reset may interrupt any state, including a held access.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= stateNext;
  end

  // Next-state logic and opcode dispatch.
  always_comb begin
    stateNext  = S_FETCH;
    illegalRaw = 1'b0;
    case (state)
      S_FETCH:  stateNext = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_RTYPE:     stateNext = S_EXEC;
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_BEQ:       stateNext = S_BRANCH;
          OP_J:         stateNext = S_JUMP;
`ifdef CTRL_ADDI_EN
          OP_ADDI:      stateNext = S_ADDIEX;
`endif
          default: begin
            stateNext  = S_FETCH;
            illegalRaw = 1'b1;
          end
        endcase
      end
      // Only lw/sw reach here and IR is stable, so re-sampling Op is safe.
      S_MEMADR: stateNext = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  stateNext = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  stateNext = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   stateNext = S_ALUWB;
`ifdef CTRL_ADDI_EN
      S_ADDIEX: stateNext = S_ADDIWB;
`endif
      default:  stateNext = S_FETCH;
    endcase
  end

  ctrl_output_decode uDecode (
    .state (state),
    .ctrl  (ctrlRaw)
  );

  // Reset forces every enable and select low, independent of the state.
  always_comb begin
    ctrlGated = rst ? CTRL_IDLE : ctrlRaw;
  end

  assign PCWrite     = ctrlGated.pcWrite & (mem_ready | ~ctrlGated.readyQual);
  assign IRWrite     = ctrlGated.irWrite & (mem_ready | ~ctrlGated.readyQual);
  assign PCWriteCond = ctrlGated.pcWriteCond;
  assign IorD        = ctrlGated.iorD;
  assign MemRead     = ctrlGated.memRead;
  assign MemWrite    = ctrlGated.memWrite;
  assign MemtoReg    = ctrlGated.memtoReg;
  assign RegDst      = ctrlGated.regDst;
  assign RegWrite    = ctrlGated.regWrite;
  assign ALUSrcA     = ctrlGated.aluSrcA;
  assign ALUSrcB     = ctrlGated.aluSrcB;
  assign ALUOp       = ctrlGated.aluOp;
  assign PCSource    = ctrlGated.pcSource;
  assign illegal_op  = illegalRaw & ~rst;
  assign state_dbg   = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. Honours CTRL_ADDI_EN the
// same way as the design.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  multicycle_control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .Op          (Op),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .illegal_op  (illegal_op),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  // All outputs except state_dbg/illegal_op, in a fixed order.
  function automatic logic [15:0] obsVec();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  // Expected Moore outputs written straight from the state/output table.
  function automatic logic [15:0] expOut(input int st, input logic rdy);
    logic pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ao, ps;
    {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
    sb = 2'd0; ao = 2'd0; ps = 2'd0;
    case (st)
      0:  begin mr = 1; sb = 2'd1; irw = rdy; pcw = rdy; end
      1:  sb = 2'd3;
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; ao = 2'd2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'd1; pcc = 1; ps = 2'd1; end
      9:  begin pcw = 1; ps = 2'd2; end
      10: begin sa = 1; sb = 2'd2; end
      11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    mem_ready = 1'b0;
    Op = 6'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] en;
    rst = 1'b1; mem_ready = 1'b1; Op = 6'b100011;
    #1;
    checks++;
    if ({obsVec(), illegal_op, state_dbg} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {obsVec(), illegal_op, state_dbg});
    end
    step();
    rst = 1'b0;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 4'd3 || MemRead !== 1'b1) begin
      errors++;
      $display("FAIL reset_reach_memrd got state=%0d MemRead=%b want 3/1", state_dbg, MemRead);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      en = {PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite, illegal_op};
      checks++;
      if (en !== 7'd0 || state_dbg !== 4'd0 || {ALUSrcB, ALUOp, PCSource} !== 6'd0) begin
        errors++;
        $display("FAIL reset_mid_memrd cyc%0d got en=%b state=%0d sel=%b want 0", i, en,
                 state_dbg, {ALUSrcB, ALUOp, PCSource});
      end
      step();
    end
    rst = 1'b0; mem_ready = 1'b1; Op = 6'b100011;
    #1;
    checks++;
    if (state_dbg !== 4'd0 || MemRead !== 1'b1 || IRWrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fetch got state=%0d MemRead=%b IRWrite=%b want 0/1/1",
               state_dbg, MemRead, IRWrite);
    end
  endtask

  task automatic test_lw();
    int exp [5] = '{0, 1, 2, 3, 4};
    doReset();
    Op = 6'b100011; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (state_dbg !== exp[i][3:0] || RegWrite !== (i == 4) || MemtoReg !== (i == 4)) begin
        errors++;
        $display("FAIL lw_cycle%0d got state=%0d RegWrite=%b MemtoReg=%b want %0d/%b/%b",
                 i, state_dbg, RegWrite, MemtoReg, exp[i], (i == 4), (i == 4));
      end
      step();
    end
    checks++;
    if (state_dbg !== 4'd0) begin
      errors++;
      $display("FAIL lw_return got state=%0d want 0", state_dbg);
    end
  endtask

  task automatic test_sw_wait();
    doReset();
    Op = 6'b101011; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (state_dbg !== i[3:0] || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
        errors++;
        $display("FAIL sw_pre%0d got state=%0d RegWrite=%b MemWrite=%b want %0d/0/0",
                 i, state_dbg, RegWrite, MemWrite, i);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      checks++;
      if (state_dbg !== 4'd5 || MemWrite !== 1'b1 || IorD !== 1'b1 || RegWrite !== 1'b0) begin
        errors++;
        $display("FAIL sw_hold%0d got state=%0d MemWrite=%b IorD=%b RegWrite=%b want 5/1/1/0",
                 i, state_dbg, MemWrite, IorD, RegWrite);
      end
      step();
    end
    #1;
    checks++;
    if (state_dbg !== 4'd0 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL sw_return got state=%0d RegWrite=%b want 0/0", state_dbg, RegWrite);
    end
  endtask

  task automatic test_branch_jump();
    doReset();
    Op = 6'b000100; mem_ready = 1'b1;
    step(); step();
    checks++;
    if (state_dbg !== 4'd8 || PCWriteCond !== 1'b1 || ALUOp !== 2'd1 || PCSource !== 2'd1) begin
      errors++;
      $display("FAIL beq got state=%0d PCWriteCond=%b ALUOp=%0d PCSource=%0d want 8/1/1/1",
               state_dbg, PCWriteCond, ALUOp, PCSource);
    end
    step();
    checks++;
    if (state_dbg !== 4'd0 || PCWriteCond !== 1'b0) begin
      errors++;
      $display("FAIL beq_return got state=%0d PCWriteCond=%b want 0/0", state_dbg, PCWriteCond);
    end
    Op = 6'b000010;
    step(); step();
    checks++;
    if (state_dbg !== 4'd9 || PCWrite !== 1'b1 || PCSource !== 2'd2) begin
      errors++;
      $display("FAIL jump got state=%0d PCWrite=%b PCSource=%0d want 9/1/2",
               state_dbg, PCWrite, PCSource);
    end
    step();
    checks++;
    if (state_dbg !== 4'd0) begin
      errors++;
      $display("FAIL jump_return got state=%0d want 0", state_dbg);
    end
  endtask

  task automatic test_illegal();
    doReset();
    Op = 6'b111111; mem_ready = 1'b1;
    #1;
    checks++;
    if (illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_fetch got %b want 0", illegal_op);
    end
    step();
    checks++;
    if (state_dbg !== 4'd1 || illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL illegal_decode got state=%0d illegal=%b want 1/1", state_dbg, illegal_op);
    end
    step();
    checks++;
    if (state_dbg !== 4'd0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_return got state=%0d illegal=%b want 0/0", state_dbg, illegal_op);
    end
  endtask

  task automatic test_addi();
    doReset();
    Op = 6'b001000; mem_ready = 1'b1;
    step();
`ifdef CTRL_ADDI_EN
    checks++;
    if (state_dbg !== 4'd1 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL addi_decode got state=%0d illegal=%b want 1/0", state_dbg, illegal_op);
    end
    step();
    checks++;
    if (state_dbg !== 4'd10 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL addi_ex got state=%0d RegWrite=%b want 10/0", state_dbg, RegWrite);
    end
    step();
    checks++;
    if (state_dbg !== 4'd11 || RegWrite !== 1'b1 || RegDst !== 1'b0) begin
      errors++;
      $display("FAIL addi_wb got state=%0d RegWrite=%b RegDst=%b want 11/1/0",
               state_dbg, RegWrite, RegDst);
    end
    step();
`else
    checks++;
    if (state_dbg !== 4'd1 || illegal_op !== 1'b1) begin
      errors++;
      $display("FAIL addi_illegal got state=%0d illegal=%b want 1/1", state_dbg, illegal_op);
    end
    step();
`endif
    checks++;
    if (state_dbg !== 4'd0) begin
      errors++;
      $display("FAIL addi_return got state=%0d want 0", state_dbg);
    end
  endtask

  // Instruction-level reference: each opcode maps to its state path; the
  // memory states (FETCH, MEMRD, MEMWR) repeat while mem_ready is low.
  task automatic test_random();
    int path[$];
    logic [5:0] op;
    logic illegalExp, rdy, isWait;
    int idx, waits;
    doReset();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: op = 6'($urandom);
      endcase
      path = {0, 1};
      illegalExp = 1'b0;
      case (op)
        6'b000000: path = {path, 6, 7};
        6'b100011: path = {path, 2, 3, 4};
        6'b101011: path = {path, 2, 5};
        6'b000100: path.push_back(8);
        6'b000010: path.push_back(9);
`ifdef CTRL_ADDI_EN
        6'b001000: path = {path, 10, 11};
`endif
        default:   illegalExp = 1'b1;
      endcase
      Op = op;
      idx = 0;
      waits = 0;
      while (idx < path.size()) begin
        isWait = (path[idx] == 0 || path[idx] == 3 || path[idx] == 5);
        rdy = (waits >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
        mem_ready = rdy;
        #1;
        checks++;
        if (state_dbg !== path[idx][3:0] || obsVec() !== expOut(path[idx], rdy) ||
            illegal_op !== (illegalExp && path[idx] == 1)) begin
          errors++;
          $display("FAIL rand op=%b step%0d got state=%0d out=%h ill=%b want %0d/%h/%b",
                   op, idx, state_dbg, obsVec(), illegal_op, path[idx],
                   expOut(path[idx], rdy), illegalExp && path[idx] == 1);
        end
        step();
        if (!isWait || rdy) begin
          idx++;
          waits = 0;
        end else begin
          waits++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; Op = 6'd0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch_jump();
    test_illegal();
    test_addi();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
